// File: rtl/xc_rf_wbq.sv
// Write-back queue between a result producer and the register-file write port.
// A circular FIFO of {addr,data} entries with an occupancy-masked hazard lookup for two decode sources.
module xc_rf_wbq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [31:0]              in_data,
    input  logic                     rd_hold,
    output logic                     rd_wen,
    output logic [4:0]               rd_addr,
    output logic [31:0]              rd_wdata,
    input  logic [4:0]               hz_addr1,
    input  logic [4:0]               hz_addr2,
    output logic                     hz_pend1,
    output logic                     hz_pend2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_off;
    logic [DEPTH-1:0] w_occ;
    logic [DEPTH-1:0] w_match1;
    logic [DEPTH-1:0] w_match2;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign in_ready = !w_full;
    // addr 0 results complete the handshake but never enter the queue
    assign w_push   = in_valid && !w_full && (in_addr != 5'd0);
    assign rd_wen   = !empty && !rd_hold;
    assign w_pop    = rd_wen;
    assign rd_addr  = empty ? '0 : r_addr[r_rptr];
    assign rd_wdata = empty ? '0 : r_data[r_rptr];

    // Storage needs no reset: stale entries are masked by occupancy everywhere.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_wptr] <= in_addr;
            r_data[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        w_off    = '0;
        w_occ    = '0;
        w_match1 = '0;
        w_match2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off       = AW'(i) - r_rptr;
            w_occ[i]    = ({1'b0, w_off} < r_count);
            w_match1[i] = (r_addr[i] == hz_addr1);
            w_match2[i] = (r_addr[i] == hz_addr2);
        end
    end

    assign hz_pend1 = (hz_addr1 != 5'd0) && |(w_occ & w_match1);
    assign hz_pend2 = (hz_addr2 != 5'd0) && |(w_occ & w_match2);

endmodule

// File: doc/xc_rf_wbq.md
XC_RF_WBQ -- requirements
Module: xc_rf_wbq

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, as the number of write-back queue entries; legal values are 2, 4 and 8 only.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the producer offers a result this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the queue can accept the offered result this cycle.
REQ-006 The block SHALL have port in_addr, input, 5 bits: the destination GPR index.
REQ-007 The block SHALL have port in_data, input, 32 bits: the destination GPR value.
REQ-008 The block SHALL have port rd_hold, input, 1 bit: the register file write port is unavailable this cycle.
REQ-009 The block SHALL have port rd_wen, output, 1 bit: the register file write enable.
REQ-010 The block SHALL have port rd_addr, output, 5 bits: the register file write index.
REQ-011 The block SHALL have port rd_wdata, output, 32 bits: the register file write data.
REQ-012 The block SHALL have ports hz_addr1 and hz_addr2, each input, 5 bits: the source indices under decode.
REQ-013 The block SHALL have ports hz_pend1 and hz_pend2, each output, 1 bit: the matching source has a queued write.
REQ-014 The block SHALL have port count, output, log2(DEPTH)+1 bits: the number of occupied entries.
REQ-015 The block SHALL have port empty, output, 1 bit: the queue holds no entries.

Function
REQ-016 The queue SHALL be a circular FIFO of DEPTH {addr,data} entries with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 in_ready SHALL equal (count != DEPTH), independent of rd_hold and in_valid.
REQ-018 A push SHALL occur on a rising edge where in_valid && in_ready && (in_addr != 0).
REQ-019 An accepted result with in_addr == 0 SHALL be consumed (handshake completes) and discarded; count, pointers and entries SHALL be unchanged.
REQ-020 rd_wen SHALL equal (!empty && !rd_hold); rd_addr and rd_wdata SHALL present the head entry and be 0 when empty.
REQ-021 A pop SHALL occur on a rising edge where rd_wen is 1.
REQ-022 Latency: a result pushed on edge N SHALL appear on rd_* in the cycle after edge N, at the earliest.
REQ-023 There SHALL be no combinational path from in_* to rd_*.
REQ-024 Ordering: entries SHALL drain in push order, including multiple writes to the same address.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, advance both pointers, and lose no data.
REQ-026 A push while full SHALL be impossible because in_ready is 0; a pop on the same edge SHALL NOT admit a same-cycle push.
REQ-027 count SHALL be incremented on a push only, decremented on a pop only, and never exceed DEPTH or drop below 0.
REQ-028 empty SHALL equal (count == 0).
REQ-029 hz_pendN SHALL be 1 iff hz_addrN != 0 and any occupied entry holds addr == hz_addrN.
REQ-030 hz_pendN SHALL include the head entry being popped this cycle and SHALL exclude the in_* result being offered this cycle.
REQ-031 Entries not occupied SHALL never contribute to hz_pend1 or hz_pend2, whatever their stale contents.

Reset
REQ-032 While resetn is 0, the pointers and count SHALL be 0, empty SHALL be 1, in_ready SHALL be 1, and rd_wen, rd_addr, rd_wdata, hz_pend1 and hz_pend2 SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL drop all queued entries immediately, without waiting for a clock edge.
REQ-034 Entry storage SHALL need no reset, because it is masked by occupancy.
REQ-035 The first push SHALL be accepted on the first rising edge after resetn deasserts.

Verification
REQ-036 The bench SHALL cover basic write-back: push (5,0xDEADBEEF), rd_hold=0 -> the next cycle rd_wen=1, rd_addr=5, rd_wdata=0xDEADBEEF; the cycle after, empty=1.
REQ-037 The bench SHALL cover the x0 drop: push (0,0x1234) -> in_ready=1, count stays 0, rd_wen stays 0, and hz_pend1 stays 0 with hz_addr1=0.
REQ-038 The bench SHALL cover fill and stall: rd_hold=1, push (1..4,0x10..0x13) with DEPTH=4 -> count=4, in_ready=0, a fifth in_valid is not accepted; then rd_hold=0 -> rd_addr 1,2,3,4 on four consecutive cycles, then empty=1.
REQ-039 The bench SHALL cover a full queue with simultaneous pop: full, rd_hold=0, in_valid=1 -> no push that cycle; the next cycle in_ready=1 and a push plus pop leave count=3; across 20 random cycles the pointers wrap with no loss or reordering.
REQ-040 The bench SHALL cover the hazard: queue holds 7 and 7 (values 0xA, 0xB), hz_addr1=7, hz_addr2=8 -> hz_pend1=1, hz_pend2=0; hz_pend1 stays 1 until the second pop, and rd_wdata is 0xA then 0xB.
REQ-041 The bench SHALL cover reset mid-drain: 3 entries queued, resetn pulsed low between edges -> immediately count=0, rd_wen=0, hz_pend1=hz_pend2=0, in_ready=1.
